// File: rtl/sgf_norm_round_unit_if.sv
// Handshake and result bundle for the significand normalize/round stage.
// The master side issues a product; the slave side returns the rounded fraction and exponent strobes.
interface sgf_norm_round_unit_if #(
    parameter int W_Sgf = 23
);
    localparam int PW = 2 * W_Sgf + 2;

    logic              start;
    logic [PW-1:0]     sgf_prod;
    logic              sign;
    logic [1:0]        round_mode;
    logic [W_Sgf-1:0]  sgf_out;
    logic              exp_na;
    logic              exp_na_vld;
    logic              post_adj;
    logic              post_adj_vld;
    logic              zero;
    logic              busy;
    logic              done;

    modport master (
        output start, sgf_prod, sign, round_mode,
        input  sgf_out, exp_na, exp_na_vld, post_adj, post_adj_vld, zero, busy, done
    );

    modport slave (
        input  start, sgf_prod, sign, round_mode,
        output sgf_out, exp_na, exp_na_vld, post_adj, post_adj_vld, zero, busy, done
    );
endinterface

// File: rtl/sgf_norm_round_unit.sv
// Normalizes a 2*W_Sgf+2 bit significand product to W_Sgf+1 bits and rounds it in one of four IEEE modes.
// One FSM state per clock: IDLE -> NORM -> RND -> (ADJ) -> DONE.
module sgf_norm_round_unit #(
    parameter int W_Sgf = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    sgf_norm_round_unit_if.slave     bus
);
    localparam int PW = 2 * W_Sgf + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NORM = 3'd1;
    localparam logic [2:0] S_RND  = 3'd2;
    localparam logic [2:0] S_ADJ  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q,        state_d;
    logic [PW-1:0]     prod_q,         prod_d;
    logic              sign_q,         sign_d;
    logic [1:0]        mode_q,         mode_d;
    logic [W_Sgf:0]    m_q,            m_d;
    logic              g_q,            g_d;
    logic              s_q,            s_d;
    logic [W_Sgf+1:0]  r_q,            r_d;
    logic [W_Sgf-1:0]  sgf_out_q,      sgf_out_d;
    logic              exp_na_q,       exp_na_d;
    logic              exp_na_vld_q,   exp_na_vld_d;
    logic              post_adj_q,     post_adj_d;
    logic              post_adj_vld_q, post_adj_vld_d;
    logic              zero_q,         zero_d;
    logic              done_q,         done_d;

    logic              norm_hi;
    logic [W_Sgf:0]    m_n;
    logic              g_n;
    logic              s_n;
    logic              inc;
    logic [W_Sgf+1:0]  r_sum;

    // Leading-one position picks which window of the product becomes the mantissa.
    always_comb begin
        norm_hi = prod_q[PW-1];
        if (norm_hi) begin
            m_n = prod_q[PW-1:W_Sgf+1];
            g_n = prod_q[W_Sgf];
            s_n = |prod_q[W_Sgf-1:0];
        end else begin
            m_n = prod_q[PW-2:W_Sgf];
            g_n = prod_q[W_Sgf-1];
            s_n = |prod_q[W_Sgf-2:0];
        end
    end

    always_comb begin
        case (mode_q)
            2'b00:   inc = g_q & (s_q | m_q[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_q & (g_q | s_q);
            default: inc = sign_q & (g_q | s_q);
        endcase
        r_sum = {1'b0, m_q} + {{(W_Sgf + 1){1'b0}}, inc};
    end

    always_comb begin
        // NOTE: every _d starts from its hold value (strobes from 0) so no path through the case can infer a latch.
        state_d        = state_q;
        prod_d         = prod_q;
        sign_d         = sign_q;
        mode_d         = mode_q;
        m_d            = m_q;
        g_d            = g_q;
        s_d            = s_q;
        r_d            = r_q;
        sgf_out_d      = sgf_out_q;
        exp_na_d       = exp_na_q;
        exp_na_vld_d   = 1'b0;
        post_adj_d     = post_adj_q;
        post_adj_vld_d = 1'b0;
        zero_d         = zero_q;
        done_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    prod_d  = bus.sgf_prod;
                    sign_d  = bus.sign;
                    mode_d  = bus.round_mode;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                m_d          = m_n;
                g_d          = g_n;
                s_d          = s_n;
                exp_na_d     = norm_hi;
                zero_d       = ~|prod_q;
                post_adj_d   = 1'b0;
                exp_na_vld_d = 1'b1;
                state_d      = S_RND;
            end
            S_RND: begin
                r_d       = r_sum;
                sgf_out_d = r_sum[W_Sgf-1:0];
                state_d   = r_sum[W_Sgf+1] ? S_ADJ : S_DONE;
            end
            S_ADJ: begin
                // A carry out means R = 10...0, so the renormalized fraction is all zeros.
                sgf_out_d      = r_q[W_Sgf:1];
                post_adj_d     = 1'b1;
                post_adj_vld_d = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state, including operand and datapath registers, is cleared on reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            prod_q         <= '0;
            sign_q         <= 1'b0;
            mode_q         <= 2'b00;
            m_q            <= '0;
            g_q            <= 1'b0;
            s_q            <= 1'b0;
            r_q            <= '0;
            sgf_out_q      <= '0;
            exp_na_q       <= 1'b0;
            exp_na_vld_q   <= 1'b0;
            post_adj_q     <= 1'b0;
            post_adj_vld_q <= 1'b0;
            zero_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
            state_q        <= state_d;
            prod_q         <= prod_d;
            sign_q         <= sign_d;
            mode_q         <= mode_d;
            m_q            <= m_d;
            g_q            <= g_d;
            s_q            <= s_d;
            r_q            <= r_d;
            sgf_out_q      <= sgf_out_d;
            exp_na_q       <= exp_na_d;
            exp_na_vld_q   <= exp_na_vld_d;
            post_adj_q     <= post_adj_d;
            post_adj_vld_q <= post_adj_vld_d;
            zero_q         <= zero_d;
            done_q         <= done_d;
        end
    end

    assign bus.sgf_out      = sgf_out_q;
    assign bus.exp_na       = exp_na_q;
    assign bus.exp_na_vld   = exp_na_vld_q;
    assign bus.post_adj     = post_adj_q;
    assign bus.post_adj_vld = post_adj_vld_q;
    assign bus.zero         = zero_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_sgf_norm_round_unit.sv
// Scoreboard bench for sgf_norm_round_unit (W_Sgf=23): driver pushes model results, a negedge monitor pops and compares.
// The reference model rounds with plain integer arithmetic on the full product.
module tb_sgf_norm_round_unit;
    localparam int W  = 23;
    localparam int PW = 2 * W + 2;

    typedef struct {
        logic [PW-1:0] p;
        logic [W-1:0]  out;
        logic          exp_na;
        logic          post_adj;
        logic          zero;
        int            lat;
        int            accept;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   env_cnt = 0;
    int   pav_cnt = 0;
    exp_t sb_q[$];

    sgf_norm_round_unit_if #(.W_Sgf(W)) bus ();

    sgf_norm_round_unit #(.W_Sgf(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: split the product at the normalized binary point, then round the integer mantissa.
    function automatic exp_t model(input logic [PW-1:0] p, input logic sg, input logic [1:0] md);
        exp_t e;
        longint unsigned pv, m, rem, half, r, lim;
        int sh;
        bit up;
        pv   = 64'(p);
        sh   = (pv >= (64'd1 << (PW - 1))) ? W + 1 : W;
        m    = pv >> sh;
        rem  = pv - (m << sh);
        half = 64'd1 << (sh - 1);
        case (md)
            2'b00:   up = (rem > half) || (rem == half && (m % 2) == 1);
            2'b01:   up = 1'b0;
            2'b10:   up = !sg && rem != 0;
            default: up = sg && rem != 0;
        endcase
        r   = m + (up ? 1 : 0);
        lim = 64'd1 << (W + 1);
        e.p      = p;
        e.exp_na = (sh == W + 1);
        e.zero   = (pv == 0);
        e.accept = 0;
        if (r == lim) begin
            e.post_adj = 1'b1;
            e.out      = '0;
            e.lat      = 4;
        end else begin
            e.post_adj = 1'b0;
            e.out      = W'(r);
            e.lat      = 3;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                exp_t e;
                done_cnt++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("sgf_out",       64'(bus.sgf_out),   64'(e.out));
                    check("exp_na",        64'(bus.exp_na),    64'(e.exp_na));
                    check("post_adj",      64'(bus.post_adj),  64'(e.post_adj));
                    check("zero",          64'(bus.zero),      64'(e.zero));
                    check("done_latency",  64'(cyc - e.accept), 64'(e.lat));
                    check("exp_na_vld_cnt",   64'(env_cnt), 64'd1);
                    check("post_adj_vld_cnt", 64'(pav_cnt), 64'(e.post_adj));
                end
                env_cnt = 0;
                pav_cnt = 0;
            end
            if (bus.exp_na_vld) begin
                env_cnt++;
                if (sb_q.size() > 0) begin
                    check("exp_na_at_vld",   64'(bus.exp_na), 64'(sb_q[0].exp_na));
                    check("exp_na_vld_time", 64'(cyc - sb_q[0].accept), 64'd1);
                end
            end
            if (bus.post_adj_vld) begin
                pav_cnt++;
                if (sb_q.size() > 0) begin
                    check("post_adj_at_vld",   64'(bus.post_adj), 64'(sb_q[0].post_adj));
                    check("post_adj_vld_time", 64'(cyc - sb_q[0].accept), 64'd3);
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) check("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() > 0) begin
            check("done_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [PW-1:0] p, input logic sg, input logic [1:0] md);
        exp_t e;
        wait_idle();
        bus.sgf_prod   = p;
        bus.sign       = sg;
        bus.round_mode = md;
        bus.start      = 1'b1;
        e = model(p, sg, md);
        e.accept = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // With pulse set, a start carrying different operands is driven while the unit is busy.
    task automatic run_op(input logic [PW-1:0] p, input logic sg, input logic [1:0] md, input bit pulse);
        issue(p, sg, md);
        if (pulse) begin
            @(negedge clk);
            bus.start      = 1'b1;
            bus.sgf_prod   = ~p;
            bus.sign       = ~sg;
            bus.round_mode = ~md;
            @(negedge clk);
            bus.start = 1'b0;
        end
        drain();
    endtask

    function automatic logic [PW-1:0] rand_prod();
        logic [63:0] r;
        logic [PW-1:0] p;
        r = {$urandom, $urandom};
        p = PW'(r);
        case ($urandom_range(0, 5))
            0:       p = p;
            1:       p = p | (48'd1 << (PW - 1));
            2:       p = (p & ~(48'd1 << (PW - 1))) | (48'd1 << (PW - 2));
            3:       p = 48'h7FFFFF800000 | (p & 48'h7FFFFF);
            4:       p = 48'hFFFFFF000000 | (p & 48'hFFFFFF);
            default: p = ($urandom_range(0, 1) == 0) ? 48'h0 : 48'h400000400000;
        endcase
        return p;
    endfunction

    initial begin
        bus.start      = 1'b0;
        bus.sgf_prod   = '0;
        bus.sign       = 1'b0;
        bus.round_mode = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({bus.sgf_out, bus.exp_na, bus.exp_na_vld, bus.post_adj, bus.post_adj_vld,
                   bus.zero, bus.busy, bus.done}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(48'h400000000000, 1'b0, 2'b00, 1'b0);
        run_op(48'h800000000000, 1'b0, 2'b00, 1'b0);
        run_op(48'h7FFFFFC00000, 1'b0, 2'b00, 1'b0);
        run_op(48'h400000400000, 1'b0, 2'b00, 1'b0);
        run_op(48'h400000400000, 1'b0, 2'b01, 1'b0);
        run_op(48'h400000400000, 1'b0, 2'b10, 1'b0);
        run_op(48'h400000400000, 1'b0, 2'b11, 1'b0);
        run_op(48'h400000400000, 1'b1, 2'b11, 1'b0);
        for (int md = 0; md < 4; md++) run_op(48'h0, 1'b1, 2'(md), 1'b0);
        run_op(48'hFFFFFF800000, 1'b0, 2'b10, 1'b1);
        run_op(48'h5A5A5A5A5A5A, 1'b1, 2'b00, 1'b1);

        // Abort in RND: no done, everything cleared one cycle later.
        begin
            int d0;
            issue(48'hFFFFFFFFFFFF, 1'b0, 2'b10);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort_outputs",
                  64'({bus.sgf_out, bus.exp_na, bus.exp_na_vld, bus.post_adj, bus.post_adj_vld,
                       bus.zero, bus.busy, bus.done}), 64'd0);
            rst = 1'b0;
            sb_q.delete();
            env_cnt = 0;
            pav_cnt = 0;
            d0 = done_cnt;
            repeat (6) @(negedge clk);
            check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        end

        // Start held high: each new operation is taken in the IDLE cycle where done is showing.
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            logic [PW-1:0] p;
            logic sg;
            logic [1:0] md;
            p  = rand_prod();
            sg = 1'($urandom);
            md = 2'($urandom);
            bus.sgf_prod   = p;
            bus.sign       = sg;
            bus.round_mode = md;
            bus.start      = 1'b1;
            wait_idle();
            if (k > 0) check("b2b_done_in_idle", 64'(bus.done), 64'd1);
            e = model(p, sg, md);
            e.accept = cyc + 1;
            sb_q.push_back(e);
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain();

        for (int i = 0; i < 40; i++)
            run_op(rand_prod(), 1'($urandom), 2'($urandom), bit'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sgf_norm_round_unit.md
SGF_NORM_ROUND_UNIT -- requirements
Module: sgf_norm_round_unit

Interface
REQ-001 Parameter: W_Sgf, default 23, stored fraction width (52 for double precision); product width PW = 2*W_Sgf+2.
REQ-002 clk  input  1  clock for all registers.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to process sgf_prod, sampled only in IDLE.
REQ-005 sgf_prod  input  PW  unsigned significand product including both hidden bits.
REQ-006 sign  input  1  result sign, used by directed rounding modes.
REQ-007 round_mode  input  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-008 sgf_out  output  W_Sgf  rounded, normalized fraction without hidden bit.
REQ-009 exp_na  output  1  normalization right-shift applied; exponent needs +1 (first update).
REQ-010 exp_na_vld  output  1  one-cycle strobe: exp_na valid, drives the exponent stage first load.
REQ-011 post_adj  output  1  rounding carried out; exponent needs a second +1.
REQ-012 post_adj_vld  output  1  one-cycle strobe: post_adj valid, drives the exponent stage second load.
REQ-013 zero  output  1  sgf_prod was all zeros.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle strobe: all outputs final.

Function
REQ-016 FSM states: IDLE, NORM, RND, ADJ, DONE; one state per clock.
REQ-017 IDLE: start=1 captures sgf_prod, sign and round_mode into registers and moves to NORM; start=0 stays in IDLE.
REQ-018 start outside IDLE is ignored; captured operands stay stable until the next accepted start.
REQ-019 NORM, when P[PW-1]=1: M = P[PW-1:W_Sgf+1], g = P[W_Sgf], s = OR(P[W_Sgf-1:0]), exp_na=1.
REQ-020 NORM, when P[PW-1]=0: M = P[PW-2:W_Sgf], g = P[W_Sgf-1], s = OR(P[W_Sgf-2:0]), exp_na=0.
REQ-021 NORM registers M (W_Sgf+1 bits), g, s, exp_na, zero (P==0), pulses exp_na_vld, then moves to RND.
REQ-022 Round increment: mode 00 g&(s|M[0]); mode 01 0; mode 10 ~sign&(g|s); mode 11 sign&(g|s).
REQ-023 RND registers R = M + inc at W_Sgf+2 bits; carry = R[W_Sgf+1]; moves to ADJ if carry=1, else DONE.
REQ-024 When carry=0, sgf_out = R[W_Sgf-1:0] and post_adj=0.
REQ-025 ADJ: R shifted right 1, so sgf_out = 0, post_adj=1, post_adj_vld pulsed; moves to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; start is not accepted in DONE.
REQ-027 Latency from the accepting clock edge to done high: 3 cycles with no carry, 4 cycles with carry.
REQ-028 sgf_out, exp_na, post_adj and zero hold their values from DONE until NORM of the next operation.
REQ-029 post_adj clears to 0 in NORM of each new operation.
REQ-030 A zero product gives sgf_out=0, exp_na=0, post_adj=0, zero=1 in every rounding mode.
REQ-031 Back-to-back: start held high is accepted again on the cycle after DONE, when the FSM is in IDLE.

Reset
REQ-032 rst=1 at a clock edge forces IDLE and clears sgf_out, exp_na, exp_na_vld, post_adj, post_adj_vld, zero, busy, done and all internal registers to 0.
REQ-033 rst in any non-IDLE state aborts the operation with no done strobe; rst has priority over start.

Verification (W_Sgf=23)
REQ-034 sgf_prod=48'h400000000000, mode 00 -> exp_na=0, sgf_out=0, post_adj=0, done 3 cycles after start.
REQ-035 sgf_prod=48'h800000000000 -> exp_na=1 with exp_na_vld one cycle after start, sgf_out=0, done at 3 cycles.
REQ-036 sgf_prod=48'h7FFFFFC00000, mode 00 -> exp_na=0, post_adj=1 with post_adj_vld strobe, sgf_out=0, done at 4 cycles.
REQ-037 sgf_prod=48'h400000400000 (tie): mode 00 -> sgf_out=0; mode 01 -> 0; mode 10 sign=0 -> 1; mode 11 sign=0 -> 0; mode 11 sign=1 -> 1.
REQ-038 sgf_prod=0 -> zero=1, sgf_out=0; rst asserted in RND -> next cycle IDLE, all outputs 0, no done; start pulsed while busy -> ignored.
